// File: rtl/multdiv_pkg.sv
// Shared state type and step-counter sizing for the multiply/divide sequencer.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MULT_STEPS_DEF = 16;
    localparam int DIV_STEPS_DEF  = 32;

    // The counter holds steps-1, so clog2 of the larger step count is enough.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int CNT_W = cnt_width(MULT_STEPS_DEF, DIV_STEPS_DEF);

endpackage

// File: rtl/multdiv_step_counter.sv
// Loadable down-counter with zero flag; tracks remaining datapath steps.
module multdiv_step_counter
    import multdiv_pkg::*;
#(
    parameter int CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [CNT_W_P-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [CNT_W_P-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W_P'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the shared iterative multiply/divide datapath.
// Build option MULTDIV_RESTART_EN: a request in LOAD or RUN aborts and restarts.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MULT_STEPS = MULT_STEPS_DEF,
    parameter int DIV_STEPS  = DIV_STEPS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_is_div,
    output logic             dp_load,
    output logic             dp_enable,
    input  logic [WIDTH-1:0] dp_result,
    input  logic             dp_ovf,
    output logic [WIDTH-1:0] result,
    output logic             result_rdy,
    output logic             exception,
    output logic             busy
);

    localparam int CW = cnt_width(MULT_STEPS, DIV_STEPS);
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_STEPS - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_STEPS - 1);

    state_t           state, state_nxt;
    logic             req, accept, zero_div, div_zero, cnt_zero;
    logic [WIDTH-1:0] result_q, done_result;
    logic             exc_q, done_exc;

    assign req      = ctrl_mult | ctrl_div;
    assign zero_div = dp_is_div && (dp_b == '0);

`ifdef MULTDIV_RESTART_EN
    assign accept = req && (state == IDLE || state == LOAD || state == RUN);
`else
    assign accept = req && (state == IDLE);
`endif

    multdiv_step_counter #(.CNT_W_P(CW)) u_step_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (state == LOAD),
        .load_val (dp_is_div ? DIV_LAST : MULT_LAST),
        .dec      (state == RUN),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dp_load    = 1'b0;
        dp_enable  = 1'b0;
        result_rdy = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: begin
                dp_load   = 1'b1;
                dp_enable = 1'b1;
                state_nxt = zero_div ? DONE : RUN;
            end
            RUN: begin
                dp_enable = 1'b1;
                if (cnt_zero) state_nxt = DONE;
            end
            DONE: begin
                result_rdy = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // An accepted request always (re)enters LOAD, aborting any operation in flight.
        if (accept) state_nxt = LOAD;
    end

    assign done_result = div_zero ? '0 : dp_result;
    assign done_exc    = div_zero | dp_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_a      <= '0;
            dp_b      <= '0;
            dp_is_div <= 1'b0;
            div_zero  <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            if (accept) begin
                dp_a      <= operand_a;
                dp_b      <= operand_b;
                dp_is_div <= ctrl_div & ~ctrl_mult;
            end
            if (state == LOAD) div_zero <= zero_div;
            if (state == DONE) begin
                result_q <= done_result;
                exc_q    <= done_exc;
            end
        end
    end

    // dp_result only settles after the final step edge, i.e. during DONE, so the
    // completing value is shown directly in DONE and held from the register after.
    assign result    = (state == DONE) ? done_result : result_q;
    assign exception = (state == DONE) ? done_exc    : exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer with a behavioural datapath model.
`timescale 1ns/1ps
module tb_multdiv_sequencer;

    localparam int MULT_STEPS = 16;
    localparam int DIV_STEPS  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] operand_a, operand_b;
    logic [31:0] dp_a, dp_b, dp_result, result;
    logic        dp_is_div, dp_load, dp_enable, dp_ovf;
    logic        result_rdy, exception, busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rdy_seen = 0;
    bit   hold_chk = 0;
    logic [31:0] hold_res;
    logic        hold_exc;

    multdiv_sequencer #(.WIDTH(32), .MULT_STEPS(MULT_STEPS), .DIV_STEPS(DIV_STEPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_is_div  (dp_is_div),
        .dp_load    (dp_load),
        .dp_enable  (dp_enable),
        .dp_result  (dp_result),
        .dp_ovf     (dp_ovf),
        .result     (result),
        .result_rdy (result_rdy),
        .exception  (exception),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Signed 32-bit multiply/divide semantics: {exception, result}.
    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input bit div);
        longint p;
        if (!div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, 32'h80000000};
        p = longint'($signed(a)) / longint'($signed(b));
        return {1'b0, p[31:0]};
    endfunction

    // Datapath model: the answer is only present once load + all steps have been enabled.
    int          en_cnt;
    logic [31:0] m_a, m_b;
    logic        m_div;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            en_cnt <= 0; m_a <= '0; m_b <= '0; m_div <= 1'b0;
        end else if (dp_load) begin
            en_cnt <= 1; m_a <= dp_a; m_b <= dp_b; m_div <= dp_is_div;
        end else if (dp_enable) begin
            en_cnt <= en_cnt + 1;
        end
    end

    always_comb begin
        {dp_ovf, dp_result} = {1'b1, 32'hDEADBEEF};
        if (en_cnt == (m_div ? DIV_STEPS + 1 : MULT_STEPS + 1)) begin
            if (m_div && m_b == 32'd0) {dp_ovf, dp_result} = {1'b0, 32'hFFFFFFFF};
            else                       {dp_ovf, dp_result} = ref_op(m_a, m_b, m_div);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {dp_a, dp_b, dp_is_div, dp_load, dp_enable, result, result_rdy, exception, busy};
    endfunction

    // Monitor: pop expectation on every completion pulse, then check the hold next cycle.
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 0;
        end else begin
            if (hold_chk) begin
                check("hold", {result, exception}, {hold_res, hold_exc});
                hold_chk = 0;
            end
            if (result_rdy) begin
                rdy_seen++;
                if (sb.size() == 0) begin
                    check("spurious_rdy", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", result, mon_e.res);
                    check("exception", exception, mon_e.exc);
                    check("latency", cyc, mon_e.due);
                    hold_res = mon_e.res;
                    hold_exc = mon_e.exc;
                    hold_chk = 1;
                end
            end
        end
    end

    // Drive a one-cycle request, push the expectation; returns in cycle 1 (LOAD).
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        bit          is_div;
        exp_t        e;
        logic [32:0] r;
        int          c;
        @(posedge clk); #1;
        c = cyc;
        ctrl_mult = m; ctrl_div = d; operand_a = a; operand_b = b;
        is_div = d && !m;
        r = ref_op(a, b, is_div);
        e.res = r[31:0];
        e.exc = r[32];
        e.due = c + (is_div ? ((b == 32'd0) ? 2 : DIV_STEPS + 2) : MULT_STEPS + 2);
        sb.push_back(e);
        @(posedge clk); #1;
        ctrl_mult = 0; ctrl_div = 0; operand_a = $urandom; operand_b = $urandom;
        check("load_ctl", {busy, dp_load, dp_enable, dp_is_div}, {3'b111, is_div});
        check("latched_ops", {dp_a, dp_b}, {a, b});
    endtask

    // Per-cycle control trace from LOAD through the cycle after DONE (cycle 'last').
    task automatic trace(input int last);
        for (int k = 1; k <= last + 1; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            check($sformatf("ctl_c%0d", k), {busy, dp_load, dp_enable},
                  (k > last) ? 3'b000 : {1'b1, k == 1, k < last});
        end
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin @(negedge clk); i++; end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int   c2, seen0, sel;
        logic [31:0] ra, rb;
        exp_t e2;
        rst = 1; ctrl_mult = 0; ctrl_div = 0; operand_a = '0; operand_b = '0;
        #2;
        check("reset_outs", outs(), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        issue(1, 0, 32'd7, 32'hFFFFFFFD);   trace(MULT_STEPS + 2);
        issue(0, 1, 32'd100, 32'd7);        trace(DIV_STEPS + 2);
        issue(0, 1, 32'd100, 32'd0);        trace(2);
        issue(1, 0, 32'h40000000, 32'd4);   wait_done();
        issue(1, 1, 32'd5, 32'd6);          wait_done();

        // Second request arriving in cycle 5 of a multiply.
        issue(1, 0, 32'd9, 32'd9);
        repeat (4) @(posedge clk);
        #1;
        c2 = cyc;
        ctrl_mult = 1; operand_a = 32'd3; operand_b = 32'd4;
`ifdef MULTDIV_RESTART_EN
        void'(sb.pop_back());
        e2.res = 32'd12; e2.exc = 1'b0; e2.due = c2 + MULT_STEPS + 2;
        sb.push_back(e2);
`endif
        @(posedge clk); #1;
        ctrl_mult = 0;
        wait_done();

        // Reset in cycle 10 of a divide.
        issue(0, 1, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1;
        sb.delete();
        seen0 = rdy_seen;
        #1;
        check("rst_outs", outs(), 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (60) @(posedge clk);
        check("no_rdy_after_rst", rdy_seen, seen0);
        issue(1, 0, 32'd11, 32'hFFFFFFF4);  wait_done();

        // Randomized back-to-back operations with corner operands mixed in.
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            ra = $urandom; rb = $urandom;
            case (sel)
                0: issue(0, 1, ra, 32'd0);
                1: issue(0, 1, 32'h80000000, 32'hFFFFFFFF);
                2: issue(1, 0, ra >> 16, rb >> 17);
                3: issue(1, 1, ra, rb);
                4, 5, 6: issue(1, 0, ra, rb);
                default: issue(0, 1, ra, rb >> $urandom_range(0, 24));
            endcase
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
